// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: widths, opcode fields,
// the IF/ID register layout and its control encoding.
package cpu_pkg;

    localparam int WORD_W     = 16;
    localparam int PC_W       = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int PC_STEP    = 2;

    localparam logic [3:0]        OP_HALT  = 4'hF;
    localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_LOAD,
        IFID_FLUSH
    } ifid_ctrl_e;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus;
        logic              valid;
    } ifid_t;

    // Unsigned PC add; the carry out of the top bit is discarded.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] pc, input int step);
        return pc + PC_W'(step);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with hold, load and flush controls. A flush
// inserts a bubble but keeps the PC fields, so it suits later stage registers too.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RST_INSTR = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  ifid_ctrl_e ctrl,
    input  ifid_t      load_data,
    output ifid_t      ifid
);

    ifid_t ifid_d;
    ifid_t ifid_q;

    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        ifid_d = ifid_q;
        unique case (ctrl)
            IFID_LOAD: ifid_d = load_data;
            IFID_FLUSH: begin
                ifid_d.instr = RST_INSTR;
                ifid_d.valid = 1'b0;
            end
            default: ifid_d = ifid_q;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_q.instr   <= RST_INSTR;
            ifid_q.pc      <= '0;
            ifid_q.pc_plus <= '0;
            ifid_q.valid   <= 1'b0;
        end else begin
            ifid_q <= ifid_d;
        end
    end

    assign ifid = ifid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and fills IF/ID. Handles stall, redirect (with flush), PC wrap and HALT.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          PC_STEP     = cpu_pkg::PC_STEP,
    parameter logic [3:0]  HALT_OPCODE = cpu_pkg::OP_HALT,
    parameter logic [15:0] NOP_WORD    = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc,
    output logic [15:0] ifid_pc_plus,
    output logic        ifid_valid,
    output logic        halted
);

    logic [PC_W-1:0] pc_d, pc_q;
    logic            halted_d, halted_q;
    ifid_ctrl_e      ifid_ctrl;
    ifid_t           ifid_load;
    ifid_t           ifid;

    // Priority per edge: redirect > stall > halted > normal fetch.
    always_comb begin
        pc_d      = pc_q;
        halted_d  = halted_q;
        ifid_ctrl = IFID_HOLD;
        ifid_load = '{instr: imem_data, pc: pc_q, pc_plus: pc_add(pc_q, PC_STEP), valid: 1'b1};

        if (redirect_valid) begin
            pc_d      = redirect_pc & ~16'h0001;
            halted_d  = 1'b0;
            ifid_ctrl = IFID_FLUSH;
        end else if (stall) begin
            ifid_ctrl = IFID_HOLD;
        end else if (halted_q) begin
            ifid_ctrl = IFID_FLUSH;
        end else begin
            ifid_ctrl = IFID_LOAD;
            // A HALT word is still issued, but the PC parks on its address.
            if (imem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_add(pc_q, PC_STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    if_id_reg #(
        .RST_INSTR (NOP_WORD)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl      (ifid_ctrl),
        .load_data (ifid_load),
        .ifid      (ifid)
    );

    assign imem_addr    = pc_q;
    assign ifid_instr   = ifid.instr;
    assign ifid_pc      = ifid.pc;
    assign ifid_pc_plus = ifid.pc_plus;
    assign ifid_valid   = ifid.valid;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then
// randomized stall/redirect traffic checked every cycle against a behavioural model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_plus;
    logic        ifid_valid;
    logic        halted;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_pc_plus   (ifid_pc_plus),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
    );

    // Instruction memory image: one HALT word at 0x0038, everything else tagged 0x1.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0038) return 16'hF000;
        return {4'h1, a[11:0]};
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model of the fetch stage, stepped directly from the rules.
    logic [15:0] m_pc, m_instr, m_ipc, m_iplus;
    logic        m_valid, m_halted;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 16'h0000; m_instr <= 16'h0000; m_ipc <= 16'h0000;
            m_iplus <= 16'h0000; m_valid <= 1'b0; m_halted <= 1'b0;
        end else if (redirect_valid) begin
            m_pc     <= {redirect_pc[15:1], 1'b0};
            m_instr  <= 16'h0000;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_halted) begin
            m_instr <= 16'h0000;
            m_valid <= 1'b0;
        end else begin
            m_instr <= mem_word(m_pc);
            m_ipc   <= m_pc;
            m_iplus <= 16'((32'(m_pc) + 2) % 65536);
            m_valid <= 1'b1;
            if (mem_word(m_pc) >> 12 == 16'hF) m_halted <= 1'b1;
            else m_pc <= 16'((32'(m_pc) + 2) % 65536);
        end
    end

    // Compare process: outputs are checked on every falling edge.
    always @(negedge clk) begin
        check("imem_addr",    imem_addr,    m_pc);
        check("ifid_instr",   ifid_instr,   m_instr);
        check("ifid_pc",      ifid_pc,      m_ipc);
        check("ifid_pc_plus", ifid_pc_plus, m_iplus);
        check("ifid_valid",   16'(ifid_valid), 16'(m_valid));
        check("halted",       16'(halted),     16'(m_halted));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #12;
        check("rst_imem_addr", imem_addr, 16'h0000);
        check("rst_valid", 16'(ifid_valid), 16'h0000);
        rst_n = 1'b1;
        #1;

        // Free run from reset.
        step();
        check("run_addr_1", imem_addr, 16'h0002);
        step();
        check("run_addr_2", imem_addr, 16'h0004);
        check("run_instr", ifid_instr, 16'h1002);
        check("run_pc", ifid_pc, 16'h0002);
        check("run_pc_plus", ifid_pc_plus, 16'h0004);
        check("run_valid", 16'(ifid_valid), 16'h0001);

        // Two-cycle stall at pc=0004.
        stall = 1'b1;
        step();
        step();
        check("stall_addr", imem_addr, 16'h0004);
        check("stall_ifid_pc", ifid_pc, 16'h0002);
        check("stall_instr", ifid_instr, 16'h1002);
        stall = 1'b0;
        step();
        check("release_ifid_pc", ifid_pc, 16'h0004);

        // Redirect to an odd target together with a stall.
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h002D;
        step();
        stall = 1'b0; redirect_valid = 1'b0;
        check("redir_addr", imem_addr, 16'h002C);
        check("redir_valid", 16'(ifid_valid), 16'h0000);
        check("redir_instr", ifid_instr, 16'h0000);
        step();
        check("redir_ifid_pc", ifid_pc, 16'h002C);

        // Run into the HALT word at 0x0038.
        repeat (5) step();
        check("pre_halt_addr", imem_addr, 16'h0038);
        step();
        check("halt_instr", ifid_instr, 16'hF000);
        check("halt_valid", 16'(ifid_valid), 16'h0001);
        check("halt_flag", 16'(halted), 16'h0001);
        check("halt_addr", imem_addr, 16'h0038);
        repeat (2) begin
            step();
            check("halt_bubble", 16'(ifid_valid), 16'h0000);
            check("halt_addr_hold", imem_addr, 16'h0038);
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        step();
        redirect_valid = 1'b0;
        check("resume_halted", 16'(halted), 16'h0000);
        check("resume_addr", imem_addr, 16'h0010);

        // PC wrap.
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_ifid_pc", ifid_pc, 16'hFFFE);
        check("wrap_pc_plus", ifid_pc_plus, 16'h0000);
        check("wrap_addr", imem_addr, 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            stall = (r < 25);
            redirect_valid = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 2))
                0: redirect_pc = 16'($urandom);
                1: redirect_pc = 16'h0030 | 16'($urandom_range(0, 15));
                default: redirect_pc = 16'hFFFC | 16'($urandom_range(0, 3));
            endcase
            step();
        end
        stall = 1'b0; redirect_valid = 1'b0;

        // Park in HALT, then reset asynchronously mid-cycle during a redirect.
        redirect_valid = 1'b1; redirect_pc = 16'h0038;
        step();
        redirect_valid = 1'b0;
        step();
        check("pre_rst_halted", 16'(halted), 16'h0001);
        redirect_valid = 1'b1; redirect_pc = 16'h1234;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_addr", imem_addr, 16'h0000);
        check("async_rst_valid", 16'(ifid_valid), 16'h0000);
        check("async_rst_halted", 16'(halted), 16'h0000);
        redirect_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (4) step();
        check("post_rst_addr", imem_addr, 16'h0008);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
